// File: rtl/chunk_adder.sv
// chunk_adder: multi-cycle WIDTH-bit adder, CHUNK bits per clock behind a start/busy/done handshake.
// Define CHUNK_ADDER_OVF_EN to add the two's-complement overflow output ovf.
module chunk_adder #(
  parameter int WIDTH = 128,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef CHUNK_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int K = WIDTH / CHUNK;
  localparam int CW = $clog2(K + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic c_q, c_d, busy_q, busy_d, done_q, done_d;
  logic [CHUNK:0] sum;
  logic accept;
`ifdef CHUNK_ADDER_OVF_EN
  logic ovf_q, ovf_d;
  assign ovf = ovf_q;
`endif
  assign sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_q};
  assign accept = start && (state_q != RUN);
  assign busy = busy_q;
  assign done = done_q;
  assign s = s_q;
  assign cout = c_q;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    s_d = s_q;
    c_d = c_q;
    cnt_d = cnt_q;
`ifdef CHUNK_ADDER_OVF_EN
    ovf_d = ovf_q;
`endif
    if (accept) begin
      a_d = a;
      b_d = b;
      c_d = cin;
      cnt_d = '0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      a_d = a_q >> CHUNK;
      b_d = b_q >> CHUNK;
      s_d = WIDTH'({sum[CHUNK-1:0], s_q} >> CHUNK);
      c_d = sum[CHUNK];
`ifdef CHUNK_ADDER_OVF_EN
      // carry into the chunk MSB recovered from its operand and sum bits
      ovf_d = sum[CHUNK] ^ a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ sum[CHUNK-1];
`endif
      cnt_d = cnt_q + 1'b1;
      state_d = (cnt_q == CW'(K - 1)) ? DONE : RUN;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
      c_q <= 1'b0;
      cnt_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef CHUNK_ADDER_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      s_q <= s_d;
      c_q <= c_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
`ifdef CHUNK_ADDER_OVF_EN
      ovf_q <= ovf_d;
`endif
    end
  end
endmodule
